cdc_reset_sequencer: RTL and testbench

Multi-output reset sequencer for one clock domain.
- Async-asserts all N_OUT reset outputs together; de-asserts them synchronously, one by one, in index order.
- Configurable synchronizer depth, minimum hold time and inter-stage spacing.
- Synchronous software reset request re-runs the whole sequence.
- Sits at the root of each clock domain and drives the reset tree of the datapath blocks (e.g. PLL-gated logic first, then FIFOs, then bus logic).

---
 rtl/cdc_reset_sequencer.sv | 170 +++++++++++++++++
 tb/tb_cdc_reset_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cdc_reset_sequencer.sv
// Ordered reset release for one clock domain: async assert, synchronized staged de-assert.
// Optional `CDC_RESET_SEQ_ACK_EN adds i_ack so each stage waits for its predecessor's ready.
module cdc_reset_sequencer #(
  parameter int unsigned N_OUT       = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned STEP_CYCLES = 2,
  parameter logic        INIT        = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_srst,
`ifdef CDC_RESET_SEQ_ACK_EN
  input  logic [N_OUT-1:0] i_ack,
`endif
  output logic [N_OUT-1:0] o_rst,
  output logic [N_OUT-1:0] o_rst_q,
  output logic             o_done
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] STEP_LD = CNT_W'(STEP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_OUT - 1);

  typedef enum logic [1:0] {S_SYNC, S_HOLD, S_STEP, S_DONE} state_e;

  // Declaration values give the configuration-time state selected by INIT.
  logic [SYNC_STAGES-1:0] sync_q  = {SYNC_STAGES{~INIT}};
  state_e                 state_q = (INIT != 1'b0) ? S_SYNC : S_DONE;
  logic [CNT_W-1:0]       cnt_q   = '0;
  logic [IDX_W-1:0]       idx_q   = '0;
  logic [N_OUT-1:0]       rst_q   = {N_OUT{INIT}};
  logic [N_OUT-1:0]       dly_q   = {N_OUT{INIT}};
  logic                   done_q  = ~INIT;

  state_e           state_d;
  logic [CNT_W-1:0] cnt_d;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] idx_nx;
  logic [IDX_W-1:0] rel_idx;
  logic [N_OUT-1:0] rst_d;
  logic [N_OUT-1:0] dly_d;
  logic             done_d;
  logic             rel_en;
  logic             done_set;
  logic             srst_hit;
  logic             sync_go;
  logic             ack_cur;
  logic             ack_last;

`ifdef CDC_RESET_SEQ_ACK_EN
  assign ack_cur  = i_ack[idx_q];
  assign ack_last = i_ack[N_OUT-1];
`else
  assign ack_cur  = 1'b1;
  assign ack_last = 1'b1;
`endif

  // Leave S_SYNC on the edge that sets the synchronizer output, so the hold window starts at E.
  assign sync_go = sync_q[SYNC_STAGES-2] | sync_q[SYNC_STAGES-1];
  assign idx_nx  = idx_q + IDX_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      state_q <= S_SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      dly_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      dly_q   <= dly_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rel_en   = 1'b0;
    rel_idx  = idx_q;
    done_set = 1'b0;
    srst_hit = 1'b0;
    case (state_q)
      S_SYNC: begin
        if (sync_go) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          rel_en  = 1'b1;
          rel_idx = '0;
          idx_d   = '0;
          cnt_d   = STEP_LD;
          state_d = S_STEP;
          if (N_OUT == 1 && ack_last) begin
            done_set = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_STEP: begin
        // idx_q == LAST here only while the final stage waits for its ready.
        if (idx_q == LAST) begin
          if (ack_cur) begin
            done_set = 1'b1;
            state_d  = S_DONE;
          end
        end else if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (ack_cur) begin
          rel_en  = 1'b1;
          rel_idx = idx_nx;
          idx_d   = idx_nx;
          cnt_d   = STEP_LD;
          if (idx_nx == LAST && ack_last) begin
            done_set = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      default: ;
    endcase
    if (i_srst && state_q != S_SYNC) begin
      srst_hit = 1'b1;
      rel_en   = 1'b0;
      done_set = 1'b0;
      state_d  = S_HOLD;
      cnt_d    = HOLD_LD;
      idx_d    = '0;
    end
  end

  always_comb begin
    rst_d  = rst_q;
    done_d = done_q;
    if (srst_hit) begin
      rst_d  = '1;
      done_d = 1'b0;
    end else begin
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (rel_en && rel_idx == IDX_W'(k)) rst_d[k] = 1'b0;
      end
      if (done_set) done_d = 1'b1;
    end
    // Delayed copy asserts with rst_d but releases one edge after it.
    dly_d = rst_q | rst_d;
  end

  assign o_rst   = rst_q;
  assign o_rst_q = dly_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_cdc_reset_sequencer.sv
// Bench for cdc_reset_sequencer: two configurations checked against an edge-count release model.
module tb_cdc_reset_sequencer;

  localparam int N0 = 3, SY0 = 2, H0 = 4, S0 = 2;
  localparam int N1 = 1, SY1 = 3, H1 = 1, S1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic srst = 1'b0;
  logic [N0-1:0] rst0, rstq0;
  logic          done0;
  logic [N1-1:0] rst1, rstq1;
  logic          done1;

  int tests = 0;
  int fails = 0;
  // n: edges since release; ancX: edge E from which release times are measured.
  int n = 0;
  int anc0 = SY0;
  int anc1 = SY1;

  always #5 clk = ~clk;

  cdc_reset_sequencer #(
    .N_OUT(N0), .SYNC_STAGES(SY0), .HOLD_CYCLES(H0), .STEP_CYCLES(S0), .INIT(1'b1)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_srst(srst),
`ifdef CDC_RESET_SEQ_ACK_EN
    .i_ack('1),
`endif
    .o_rst(rst0), .o_rst_q(rstq0), .o_done(done0)
  );

  cdc_reset_sequencer #(
    .N_OUT(N1), .SYNC_STAGES(SY1), .HOLD_CYCLES(H1), .STEP_CYCLES(S1), .INIT(1'b1)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_srst(srst),
`ifdef CDC_RESET_SEQ_ACK_EN
    .i_ack('1),
`endif
    .o_rst(rst1), .o_rst_q(rstq1), .o_done(done1)
  );

  function automatic logic [7:0] exp_vec(int edge_n, int anchor, int nout, int hold, int stp, int lag);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < nout; k++) v[k] = (edge_n < anchor + hold + k * stp + lag);
    return v;
  endfunction

  function automatic logic [7:0] exp_done(int edge_n, int anchor, int nout, int hold, int stp);
    return (edge_n >= anchor + hold + (nout - 1) * stp) ? 8'd1 : 8'd0;
  endfunction

  task automatic cmp(input string tag, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d got=%b want=%b", tag, n, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".rst0"},   8'(rst0),  exp_vec(n, anc0, N0, H0, S0, 0));
    cmp({tag, ".rstq0"},  8'(rstq0), exp_vec(n, anc0, N0, H0, S0, 1));
    cmp({tag, ".done0"},  8'(done0), exp_done(n, anc0, N0, H0, S0));
    cmp({tag, ".rst1"},   8'(rst1),  exp_vec(n, anc1, N1, H1, S1, 0));
    cmp({tag, ".rstq1"},  8'(rstq1), exp_vec(n, anc1, N1, H1, S1, 1));
    cmp({tag, ".done1"},  8'(done1), exp_done(n, anc1, N1, H1, S1));
  endtask

  task automatic model_async_reset();
    n    = 0;
    anc0 = SY0;
    anc1 = SY1;
  endtask

  task automatic step(input logic rn, input logic sr, input string tag);
    @(negedge clk);
    rst_n = rn;
    srst  = sr;
    if (!rn) begin
      model_async_reset();
      #1;
      check_all({tag, ".async"});
    end
    @(posedge clk);
    if (!rst_n) begin
      model_async_reset();
    end else begin
      n++;
      if (srst && n > anc0) anc0 = n;
      if (srst && n > anc1) anc1 = n;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // Power-on reset, then the default release sequence.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "por");
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, "seq");

    // Software reset from S_DONE on edges 18..20.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "srst_done");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "srst_rel");

    // Software reset pulse at E+2 while in S_HOLD.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, "rst2");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "hold_pre");
    step(1'b1, 1'b1, "hold_srst");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "hold_rel");

    // Short async drop between edges while dut0 is in S_STEP.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, "rst3");
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, "pre_drop");
    #1;
    rst_n = 1'b0;
    model_async_reset();
    #1;
    check_all("mid_drop");
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, "post_drop");

    // Random mix of software resets and async reset pulses.
    for (int i = 0; i < 400; i++) begin
      logic rn;
      logic sr;
      rn = ($urandom_range(0, 59) != 0);
      sr = ($urandom_range(0, 9) == 0);
      step(rn, sr, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
